// File: rtl/decoder3_5_pkg.sv
// Shared types and channel code map for the five-way
// round-robin front end of the 3-to-5 decoder.
package decoder3_5_pkg;

  localparam int NUM_CH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [2:0] CODE_CH0 = 3'o0;
  localparam logic [2:0] CODE_CH1 = 3'o2;
  localparam logic [2:0] CODE_CH2 = 3'o3;
  localparam logic [2:0] CODE_CH3 = 3'o6;
  localparam logic [2:0] CODE_CH4 = 3'o7;

  function automatic logic [2:0] ch_code(
    input logic [2:0] idx
  );
    logic [2:0] c;
    case (idx)
      3'd0:    c = CODE_CH0;
      3'd1:    c = CODE_CH1;
      3'd2:    c = CODE_CH2;
      3'd3:    c = CODE_CH3;
      3'd4:    c = CODE_CH4;
      default: c = 3'o0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decoder3_5_arb_rr_pick5.sv
// Combinational round-robin picker: first requester at or
// above ptr, wrapping 4->0, as one-hot and index.
module rr_pick5
  import decoder3_5_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] pick,
  output logic [2:0] index
);

  logic [3:0] s;
  logic       found;

  always_comb begin
    pick  = '0;
    index = '0;
    found = 1'b0;
    s     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s = {1'b0, ptr} + 4'(i);
      if (s >= 4'd5) s = s - 4'd5;
      if (!found && s < 4'd5 && req[s[2:0]]) begin
        found          = 1'b1;
        pick[s[2:0]]   = 1'b1;
        index          = s[2:0];
      end
    end
  end

endmodule

// File: rtl/decoder3_5_arb.sv
// Round-robin sequencer sharing one 3-to-5 active-low decoder
// among five requesters, with hold limit and idle gap.
module decoder3_5_arb
  import decoder3_5_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  output logic [4:0] grant,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [4:0] sel_n,
  output logic       grant_valid,
  output logic       timeout
);

  state_t     state_q, state_d;
  logic [4:0] grant_q, grant_d;
  logic [2:0] code_q, code_d;
  logic [4:0] seln_q, seln_d;
  logic       gv_q, gv_d;
  logic       tmo_q, tmo_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gidx_q, gidx_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;

  logic [4:0] pick;
  logic [2:0] pidx;

  rr_pick5 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .index (pidx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    code_d  = code_q;
    seln_d  = seln_q;
    gv_d    = gv_q;
    tmo_d   = 1'b0;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          grant_d = pick;
          code_d  = ch_code(pidx);
          seln_d  = ~pick;
          gv_d    = 1'b1;
          gidx_d  = pidx;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        // a still-held request at the limit is a revoke
        if (!req[gidx_q] ||
            hold_q == 8'(HOLD_MAX)) begin
          state_d = GAP;
          tmo_d   = req[gidx_q];
          ptr_d   = (gidx_q == 3'd4) ? 3'd0
                                     : gidx_q + 3'd1;
          grant_d = '0;
          code_d  = 3'o0;
          seln_d  = '1;
          gv_d    = 1'b0;
          gap_d   = 4'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == 4'(GAP_CYC)) state_d = IDLE;
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      code_q  <= 3'o0;
      seln_q  <= '1;
      gv_q    <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      code_q  <= code_d;
      seln_q  <= seln_d;
      gv_q    <= gv_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign grant       = grant_q;
  assign {A, B, C}   = code_q;
  assign sel_n       = seln_q;
  assign grant_valid = gv_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_decoder3_5_arb.sv
// Scoreboard bench: stimulus queues expected grant episodes,
// a negedge monitor checks each episode as it completes.
module tb_decoder3_5_arb;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [4:0] req, req2;

  logic [4:0] g1, sn1, g2, sn2;
  logic       a1, b1, c1, gv1, t1;
  logic       a2, b2, c2, gv2, t2;

  decoder3_5_arb #(.HOLD_MAX(4), .GAP_CYC(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (g1),
    .A           (a1),
    .B           (b1),
    .C           (c1),
    .sel_n       (sn1),
    .grant_valid (gv1),
    .timeout     (t1)
  );

  decoder3_5_arb #(.HOLD_MAX(2), .GAP_CYC(3)) dut2 (
    .clk         (clk),
    .rst         (rst2),
    .req         (req2),
    .grant       (g2),
    .A           (a2),
    .B           (b2),
    .C           (c2),
    .sel_n       (sn2),
    .grant_valid (gv2),
    .timeout     (t2)
  );

  always #5 clk = ~clk;

  logic [4:0] g_m[2], sn_m[2];
  logic [2:0] c_m[2];
  logic       gv_m[2], t_m[2];

  assign g_m[0]  = g1;
  assign g_m[1]  = g2;
  assign sn_m[0] = sn1;
  assign sn_m[1] = sn2;
  assign c_m[0]  = {a1, b1, c1};
  assign c_m[1]  = {a2, b2, c2};
  assign gv_m[0] = gv1;
  assign gv_m[1] = gv2;
  assign t_m[0]  = t1;
  assign t_m[1]  = t2;

  typedef struct {
    logic [4:0] grant;
    logic [2:0] code;
    int         len;
    bit         tmo;
    int         gap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req_v);
    end
  endtask

  task automatic push(input int d,
                      input logic [4:0] g,
                      input logic [2:0] c,
                      input int len,
                      input bit tmo,
                      input int gap);
    exp_t e;
    e.grant = g;
    e.code  = c;
    e.len   = len;
    e.tmo   = tmo;
    e.gap   = gap;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // monitor
  bit         act_f[2];
  int         cnt[2];
  int         idle[2];
  int         gseen[2];
  logic [4:0] cg[2], cs[2];
  logic [2:0] cc[2];

  initial begin : mon
    exp_t       e;
    logic [4:0] inv;
    bit         have;
    for (int d = 0; d < 2; d++) begin
      act_f[d] = 0;
      cnt[d]   = 0;
      idle[d]  = 0;
      gseen[d] = 0;
      cg[d]    = '0;
      cs[d]    = '0;
      cc[d]    = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (gv_m[d]) begin
          if (!act_f[d]) begin
            act_f[d] = 1;
            cnt[d]   = 1;
            cg[d]    = g_m[d];
            cc[d]    = c_m[d];
            cs[d]    = sn_m[d];
            gseen[d] = idle[d];
          end else begin
            cnt[d]++;
            chk("hold_grant", 32'(g_m[d]), 32'(cg[d]));
            chk("hold_code", 32'(c_m[d]), 32'(cc[d]));
          end
          inv = ~g_m[d];
          chk("sel_vs_grant", 32'(sn_m[d]), 32'(inv));
          chk("tmo_in_grant", 32'(t_m[d]), 32'd0);
        end else begin
          if (act_f[d]) begin
            act_f[d] = 0;
            idle[d]  = 1;
            have = (d == 0) ? (q0.size() > 0)
                            : (q1.size() > 0);
            if (!have) begin
              checks++;
              failures++;
              $display("FAIL unexpected_grant dut=%0d actual=%0h required=none",
                       d, cg[d]);
            end else begin
              if (d == 0) e = q0.pop_front();
              else e = q1.pop_front();
              inv = ~e.grant;
              chk("ep_grant", 32'(cg[d]), 32'(e.grant));
              chk("ep_code", 32'(cc[d]), 32'(e.code));
              chk("ep_sel_n", 32'(cs[d]), 32'(inv));
              chk("ep_len", cnt[d], e.len);
              chk("ep_timeout", 32'(t_m[d]), 32'(e.tmo));
              if (e.gap >= 0)
                chk("ep_gap", gseen[d], e.gap);
            end
          end else begin
            idle[d]++;
            chk("tmo_idle", 32'(t_m[d]), 32'd0);
          end
          chk("sel_idle", 32'(sn_m[d]), 32'h1f);
          chk("code_idle", 32'(c_m[d]), 32'd0);
          chk("grant_idle", 32'(g_m[d]), 32'd0);
        end
      end
    end
  end

  initial begin : stim
    rst  = 1'b1;
    rst2 = 1'b1;
    req  = 5'b11111;
    req2 = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_n", 32'(sn1), 32'h1f);
    chk("rst_grant", 32'(g1), 32'd0);
    chk("rst_gv", 32'(gv1), 32'd0);
    chk("rst_code", 32'({a1, b1, c1}), 32'd0);

    // all requesting: rotation with timeout every grant
    push(0, 5'b00001, 3'o0, 4, 1, -1);
    push(0, 5'b00010, 3'o2, 4, 1, 2);
    push(0, 5'b00100, 3'o3, 4, 1, 2);
    push(0, 5'b01000, 3'o6, 4, 1, 2);
    push(0, 5'b10000, 3'o7, 4, 1, 2);
    push(0, 5'b00001, 3'o0, 4, 1, 2);
    rst  = 1'b0;
    rst2 = 1'b0;
    repeat (35) @(posedge clk);
    #1 req = 5'b00000;
    repeat (3) @(posedge clk);
    #1;

    // lone ch2 dropped after 3 grant cycles
    push(0, 5'b00100, 3'o3, 3, 0, -1);
    req = 5'b00100;
    repeat (3) @(posedge clk);
    #1 req = 5'b00000;
    repeat (4) @(posedge clk);
    #1;

    // ch3 held, ch1 arrives mid-grant and waits
    push(0, 5'b01000, 3'o6, 3, 0, -1);
    push(0, 5'b00010, 3'o2, 2, 0, 2);
    req = 5'b01000;
    repeat (2) @(posedge clk);
    #1 req = 5'b01010;
    @(posedge clk);
    #1 req = 5'b00010;
    repeat (4) @(posedge clk);
    #1 req = 5'b00000;
    repeat (4) @(posedge clk);
    #1;

    // async reset in the middle of a ch4 grant
    push(0, 5'b10000, 3'o7, 2, 0, -1);
    push(0, 5'b00001, 3'o0, 2, 0, -1);
    req = 5'b10000;
    repeat (2) @(posedge clk);
    #7 rst = 1'b1;
    #1;
    chk("arst_grant", 32'(g1), 32'd0);
    chk("arst_sel_n", 32'(sn1), 32'h1f);
    chk("arst_gv", 32'(gv1), 32'd0);
    chk("arst_code", 32'({a1, b1, c1}), 32'd0);
    chk("arst_tmo", 32'(t1), 32'd0);
    req = 5'b10001;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 req = 5'b00000;
    repeat (4) @(posedge clk);
    #1;

    // HOLD_MAX=2, GAP_CYC=3: lone ch2 held forever
    push(1, 5'b00100, 3'o3, 2, 1, -1);
    push(1, 5'b00100, 3'o3, 2, 1, 4);
    push(1, 5'b00100, 3'o3, 2, 1, 4);
    req2 = 5'b00100;
    repeat (16) @(posedge clk);
    #1 req2 = 5'b00000;

    for (int i = 0; i < 200; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("sb_drained0", q0.size(), 0);
    chk("sb_drained1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
